// File: rtl/conv2_pkg.sv
// Shared parameters, state encoding and derived widths for the conv2 filter scheduler.
package conv2_pkg;

    localparam int N_FILT  = 3;
    localparam int DATA_W  = 14;
    localparam int MAP_POS = 64;
    localparam int TIMEOUT = 15;

    localparam int SEL_W = $clog2(N_FILT);
    localparam int POS_W = $clog2(MAP_POS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/conv2_pos_cnt.sv
// Output-position counter over the 8x8 feature map: flags the last position,
// wraps to zero after it and pulses frame_done on the cycle after that wrap.
module conv2_pos_cnt
    import conv2_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic advance,
    output logic last,
    output logic frame_done
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic             frame_done_q, frame_done_d;

    assign last       = (pos_q == POS_W'(MAP_POS - 1));
    assign frame_done = frame_done_q;

    // Step the position on each accepted output; wrap and flag the frame end at the last one.
    always_comb begin
        pos_d        = pos_q;
        frame_done_d = 1'b0;
        if (advance) begin
            if (last) begin
                pos_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                pos_d = pos_q + POS_W'(1);
            end
        end
    end

    // Position and frame-done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: rtl/conv2_filt_sched.sv
// Time-multiplexes one conv2 channel-sum engine across N_FILT filters per window,
// packs the per-filter results and hands them to pooling over valid/ready.
module conv2_filt_sched
    import conv2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     win_valid,
    output logic                     win_ready,
    output logic                     calc_start,
    output logic [SEL_W-1:0]         calc_sel,
    input  logic                     calc_valid,
    input  logic [DATA_W-1:0]        calc_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_FILT*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     err
);

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          idx_q, idx_d;
    logic [TO_W-1:0]           to_q, to_d;
    logic [N_FILT*DATA_W-1:0]  slots_q, slots_d;
    logic                      err_q, err_d;
    logic                      idle_ready;
    logic                      advance;
    logic                      pos_last;
    logic [TO_W-1:0]           to_inc;

    assign to_inc = to_q + TO_W'(1);

    // Next-state, datapath updates and handshake outputs of the scheduling FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        to_d       = to_q;
        slots_d    = slots_q;
        err_d      = err_q;
        idle_ready = 1'b0;
        calc_start = 1'b0;
        out_valid  = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                idle_ready = 1'b1;
                if (win_valid) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                calc_start = 1'b1;
                to_d       = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (calc_valid) begin
                    for (int k = 0; k < N_FILT; k++) begin
                        if (idx_q == SEL_W'(k)) begin
                            slots_d[k*DATA_W +: DATA_W] = calc_data;
                        end
                    end
                    if (idx_q == SEL_W'(N_FILT - 1)) begin
                        state_d = OUT;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = ISSUE;
                    end
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    advance = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An engine result arriving when nothing is outstanding is a protocol error.
        if (calc_valid && (state_q != WAIT)) begin
            err_d = 1'b1;
        end
    end

    // Scheduler state, filter index, timeout counter, result slots and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            to_q    <= '0;
            slots_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            to_q    <= to_d;
            slots_q <= slots_d;
            err_q   <= err_d;
        end
    end

    conv2_pos_cnt u_pos_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .last       (pos_last),
        .frame_done (frame_done)
    );

    // win_ready is held low while reset is asserted so every output reads 0 during reset.
    assign win_ready = idle_ready & rst_n;
    assign calc_sel  = idx_q;
    assign out_data  = slots_q;
    assign out_last  = out_valid & pos_last;
    assign err       = err_q;

endmodule
